// File: rtl/br_generator_frac_if.sv
// Control/status bundle for the fractional baud-rate generator.
// master: the register block / UART core that programs the generator and consumes ticks.
// slave:  the generator itself.
interface br_generator_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              en;
  logic              resync;
  logic              div_wr;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_pend;
  logic              tick;
  logic              bit_tick;

  modport master (
    output en, resync, div_wr, div_int, div_frac,
    input  div_pend, tick, bit_tick
  );

  modport slave (
    input  en, resync, div_wr, div_int, div_frac,
    output div_pend, tick, bit_tick
  );
endinterface

// File: rtl/br_generator_frac.sv
// Runtime-programmable baud-rate generator with integer+fraction divisor.
// Produces an oversample tick (tick) and a bit tick (bit_tick, every OVS-th tick).
// Divisor writes land in a shadow register and are applied only at a period boundary
// (or immediately when the generator is idle/resyncing), so periods are never cut short.
// Optional macro BRG_FRAC_EN: when defined, a fractional accumulator stretches a period by
// one cycle on each accumulator overflow; when undefined, the period is div_int only.
module br_generator_frac #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 19200,
  parameter int OVS       = 16,
  parameter int DIV_W     = 16,
  parameter int FRAC_W    = 4
) (
  input logic               clk,
  input logic               reset,
  br_generator_frac_if.slave bus
);

  localparam int OVS_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [63:0] DIV_RST =
    (64'(CLK_FREQ) << FRAC_W) / (64'(BAUD_RATE) * 64'(OVS));
  localparam logic [DIV_W-1:0] RST_INT  = DIV_RST[FRAC_W +: DIV_W];
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

  // Periods shorter than two cycles would make tick back-to-back; saturate at 2.
  function automatic logic [DIV_W-1:0] clamp_int(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  logic [DIV_W-1:0] act_int;
  logic [DIV_W-1:0] shd_int;
  logic             pend;
  logic [DIV_W-1:0] cnt;
  logic [OVS_W-1:0] ovs_cnt;
  logic             tick_flag;
  logic             bit_flag;
  logic [DIV_W:0]   period;
  logic [DIV_W:0]   last_cnt;
  logic             boundary;
  logic             apply;
  logic             carry;

`ifdef BRG_FRAC_EN
  localparam logic [FRAC_W-1:0] RST_FRAC = DIV_RST[FRAC_W-1:0];

  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] shd_frac;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, act_frac};

  // Fractional divisor fields and accumulator; carry stretches the following period by one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_frac <= RST_FRAC;
      shd_frac <= RST_FRAC;
      acc      <= '0;
      carry    <= 1'b0;
    end else begin
      if (apply) act_frac <= shd_frac;
      if (bus.div_wr) shd_frac <= bus.div_frac;
      if (bus.resync || apply) begin
        acc   <= '0;
        carry <= 1'b0;
      end else if (boundary) begin
        {carry, acc} <= acc_sum;
      end
    end
  end
`else
  assign carry = 1'b0;
`endif

  // Current period length, end-of-period detect and shadow-apply decision.
  always_comb begin
    period   = {1'b0, clamp_int(act_int)} + {{DIV_W{1'b0}}, carry};
    last_cnt = period - (DIV_W+1)'(1);
    boundary = bus.en && ({1'b0, cnt} == last_cnt);
    // A pending divisor waits for a boundary while running, but is taken at once when idle.
    apply    = pend && (bus.resync || !bus.en || boundary);
  end

  // Integer divisor: active copy, shadow copy and pending flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_int <= RST_INT;
      shd_int <= RST_INT;
      pend    <= 1'b0;
    end else begin
      if (apply) act_int <= shd_int;
      if (bus.div_wr) begin
        shd_int <= bus.div_int;
        pend    <= 1'b1;
      end else if (apply) begin
        pend    <= 1'b0;
      end
    end
  end

  // Period counter, oversample counter and registered tick pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      ovs_cnt   <= '0;
      tick_flag <= 1'b0;
      bit_flag  <= 1'b0;
    end else if (bus.resync) begin
      cnt       <= '0;
      ovs_cnt   <= '0;
      tick_flag <= 1'b0;
      bit_flag  <= 1'b0;
    end else if (!bus.en) begin
      tick_flag <= 1'b0;
      bit_flag  <= 1'b0;
      if (apply) cnt <= '0;
    end else if (boundary) begin
      cnt       <= '0;
      tick_flag <= 1'b1;
      bit_flag  <= (ovs_cnt == OVS_LAST);
      ovs_cnt   <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + OVS_W'(1);
    end else begin
      cnt       <= cnt + DIV_W'(1);
      tick_flag <= 1'b0;
      bit_flag  <= 1'b0;
    end
  end

  assign bus.tick     = tick_flag;
  assign bus.bit_tick = bit_flag;
  assign bus.div_pend = pend;

endmodule
